// File: rtl/ws2812b_pkg.sv
// Shared types and default timing for the WS2812B receive and transmit paths.
// The receiver's optional forwarding output is enabled by defining WS2812B_FORWARD_EN.
package ws2812b_pkg;

  localparam int unsigned PIXEL_W          = 24;
  localparam int unsigned BIT_CNT_W        = 5;

  // Nominal bit timing in 100 MHz cycles, shared with the strip driver.
  localparam int unsigned T0H_CYCLES       = 40;
  localparam int unsigned T0L_CYCLES       = 85;
  localparam int unsigned T1H_CYCLES       = 80;
  localparam int unsigned T1L_CYCLES       = 45;
  localparam int unsigned RESET_CYCLES_DEF = 5000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    RESYNC = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_pixel_t;

endpackage

// File: rtl/ws2812b_sync_edge.sv
// Two-flop synchronizer for the asynchronous data line, plus rise/fall detection
// on the synchronized value (edges are combinational, one cycle wide).
module ws2812b_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o_c,
  output logic fall_o_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o   = sync_q;
  assign rise_o_c = sync_q & ~prev_q;
  assign fall_o_c = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812B NRZ receiver: measures each high pulse, rebuilds 24-bit GRB words,
// detects the latch gap, and flags malformed pulses. Pass-through output when
// WS2812B_FORWARD_EN is defined (first pixel of each frame stripped).
module ws2812b_receiver
  import ws2812b_pkg::*;
#(
  parameter int unsigned BIT_THRESH   = 60,
  parameter int unsigned MIN_HIGH     = 20,
  parameter int unsigned MAX_HIGH     = 120,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int unsigned INDEX_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [PIXEL_W-1:0]   pixelData,
  output logic                 pixelValid,
  output logic [INDEX_W-1:0]   pixelIndex,
  output logic                 frameDone,
  output logic                 bitError,
  output logic                 dout
);

  localparam int unsigned HCNT_W = $clog2(MAX_HIGH + 2);
  localparam int unsigned HLEN_W = HCNT_W + 1;
  localparam int unsigned LCNT_W = $clog2(RESET_CYCLES + 1);

  logic din_sync;
  logic din_rise_c;
  logic din_fall_c;

  ws2812b_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .din_i    (din),
    .sync_o   (din_sync),
    .rise_o_c (din_rise_c),
    .fall_o_c (din_fall_c)
  );

  rx_state_e              state_q, state_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
  logic [LCNT_W-1:0]      lcnt_q, lcnt_d;
  logic [BIT_CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [PIXEL_W-1:0]     shift_q, shift_d;
  logic [INDEX_W-1:0]     idx_q, idx_d;
  grb_pixel_t             pix_q, pix_d;
  logic [INDEX_W-1:0]     pindex_q, pindex_d;
  logic                   pvalid_q, pvalid_d;
  logic                   fdone_q, fdone_d;
  logic                   berr_q, berr_d;

  // Pulse width includes the cycle on which the fall is seen.
  logic [HLEN_W-1:0]      high_len;
  logic                   pulse_bad;
  logic                   bit_one;
  logic                   low_done;
  logic [PIXEL_W-1:0]     shift_next;

  assign high_len   = HLEN_W'(hcnt_q) + HLEN_W'(1);
  assign pulse_bad  = (high_len < HLEN_W'(MIN_HIGH)) || (high_len > HLEN_W'(MAX_HIGH));
  assign bit_one    = (high_len >= HLEN_W'(BIT_THRESH));
  assign low_done   = (lcnt_q == LCNT_W'(RESET_CYCLES - 1));
  assign shift_next = {shift_q[PIXEL_W-2:0], bit_one};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (din_rise_c) state_d = HIGH;
      HIGH:    if (din_fall_c) state_d = pulse_bad ? RESYNC : LOW;
      LOW: begin
        if (din_rise_c)    state_d = HIGH;
        else if (low_done) state_d = IDLE;
      end
      RESYNC:  if (!din_sync && low_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    pindex_d = pindex_q;
    pvalid_d = 1'b0;
    fdone_d  = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_rise_c) hcnt_d = '0;
      end
      HIGH: begin
        if (din_fall_c) begin
          lcnt_d = '0;
          if (pulse_bad) begin
            berr_d  = 1'b1;
            bcnt_d  = '0;
            shift_d = '0;
          end else if (bcnt_q == BIT_CNT_W'(PIXEL_W - 1)) begin
            // 24th bit: publish the word with the index it belongs to
            bcnt_d   = '0;
            shift_d  = '0;
            pix_d    = grb_pixel_t'(shift_next);
            pvalid_d = 1'b1;
            pindex_d = idx_q;
            idx_d    = (&idx_q) ? idx_q : idx_q + INDEX_W'(1);
          end else begin
            bcnt_d  = bcnt_q + BIT_CNT_W'(1);
            shift_d = shift_next;
          end
        end else if (hcnt_q != HCNT_W'(MAX_HIGH + 1)) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      LOW: begin
        if (din_rise_c) begin
          hcnt_d = '0;
        end else if (low_done) begin
          fdone_d  = 1'b1;
          bcnt_d   = '0;
          shift_d  = '0;
          idx_d    = '0;
          pindex_d = '0;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end
      RESYNC: begin
        if (din_sync)       lcnt_d = '0;
        else if (!low_done) lcnt_d = lcnt_q + LCNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      pindex_q <= '0;
      pvalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      pindex_q <= pindex_d;
      pvalid_q <= pvalid_d;
      fdone_q  <= fdone_d;
      berr_q   <= berr_d;
    end
  end

  assign pixelData  = pix_q;
  assign pixelValid = pvalid_q;
  assign pixelIndex = pindex_q;
  assign frameDone  = fdone_q;
  assign bitError   = berr_q;

`ifdef WS2812B_FORWARD_EN
  // Pass decision is taken at each rise and held for the whole pulse.
  logic pass_q, pass_d;
  logic fwd_q, fwd_d;

  always_comb begin
    pass_d = pass_q;
    if (din_rise_c) pass_d = (idx_q != '0) && (state_q != RESYNC);
    fwd_d = din_sync & pass_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q <= 1'b0;
      fwd_q  <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fwd_q  <= fwd_d;
    end
  end

  assign dout = fwd_q;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Directed/randomized bench for ws2812b_receiver with a pulse-level reference model.
// Forwarding checks follow WS2812B_FORWARD_EN.
module tb_ws2812b_receiver;
  import ws2812b_pkg::*;

  localparam int unsigned BIT_THRESH = 60;
  localparam int unsigned MIN_HIGH   = 20;
  localparam int unsigned MAX_HIGH   = 120;
  localparam int unsigned RST_CYC    = 5000;
  localparam int unsigned INDEX_W    = 8;
  localparam int unsigned GAP        = RST_CYC + 60;

  logic               clk = 1'b0;
  logic               reset;
  logic               din;
  logic [23:0]        pixelData;
  logic               pixelValid;
  logic [INDEX_W-1:0] pixelIndex;
  logic               frameDone;
  logic               bitError;
  logic               dout;

  ws2812b_receiver #(
    .BIT_THRESH   (BIT_THRESH),
    .MIN_HIGH     (MIN_HIGH),
    .MAX_HIGH     (MAX_HIGH),
    .RESET_CYCLES (RST_CYC),
    .INDEX_W      (INDEX_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .pixelData  (pixelData),
    .pixelValid (pixelValid),
    .pixelIndex (pixelIndex),
    .frameDone  (frameDone),
    .bitError   (bitError),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [23:0] data; logic [7:0] idx; } pix_t;
  typedef struct { int rise; int width; } pulse_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;

  // reference model state
  int unsigned m_bits = 0;
  logic [23:0] m_shift = '0;
  int unsigned m_idx = 0;
  bit          m_in_frame = 1'b0;
  bit          m_resync = 1'b0;
  pix_t        exp_q[$];
  int          exp_frames = 0;
  int          exp_berr = 0;

  // observed
  pix_t        got_q[$];
  int          pv_lat_q[$];
  int          fd_lat_q[$];
  int          got_frames = 0;
  int          got_berr = 0;
  int          coincide = 0;
  pulse_t      din_p[$];
  pulse_t      dout_p[$];
  logic        dout_prev = 1'b0;
  int          dout_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (pixelValid) begin
        got_q.push_back({pixelData, 8'(pixelIndex)});
        pv_lat_q.push_back(cyc - last_fall);
      end
      if (frameDone) begin
        got_frames++;
        fd_lat_q.push_back(cyc - last_fall);
      end
      if (bitError) got_berr++;
      if (pixelValid && frameDone) coincide++;
    end
    if (dout && !dout_prev) dout_rise = cyc;
    if (!dout && dout_prev) dout_p.push_back('{rise: dout_rise, width: cyc - dout_rise});
    dout_prev = dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One high pulse of h cycles then l low cycles; model applies the decode rules.
  task automatic send_pulse(input int unsigned h, input int unsigned l);
    if (!m_resync) begin
      if (h < MIN_HIGH || h > MAX_HIGH) begin
        exp_berr++;
        m_bits = 0;
        m_shift = '0;
        m_in_frame = 1'b0;
        m_resync = 1'b1;
      end else begin
        m_shift = {m_shift[22:0], (h >= BIT_THRESH) ? 1'b1 : 1'b0};
        m_bits++;
        m_in_frame = 1'b1;
        if (m_bits == 24) begin
          exp_q.push_back({m_shift, 8'(m_idx)});
          m_bits = 0;
          if (m_idx < (1 << INDEX_W) - 1) m_idx++;
        end
      end
    end
    @(negedge clk);
    din = 1'b1;
    din_p.push_back('{rise: cyc, width: int'(h)});
    repeat (h) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    repeat (l - 1) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int nbits, input bit rnd);
    for (int i = 23; i >= 24 - nbits; i--) begin
      int unsigned h;
      int unsigned l;
      if (w[i]) begin
        h = rnd ? $urandom_range(MAX_HIGH - 2, BIT_THRESH + 2) : T1H_CYCLES;
        l = rnd ? $urandom_range(40, 5) : T1L_CYCLES;
      end else begin
        h = rnd ? $urandom_range(BIT_THRESH - 3, MIN_HIGH + 2) : T0H_CYCLES;
        l = rnd ? $urandom_range(40, 5) : T0L_CYCLES;
      end
      send_pulse(h, l);
    end
  endtask

  task automatic send_gap(input int unsigned n);
    if (n >= RST_CYC) begin
      if (m_resync) begin
        m_resync = 1'b0;
      end else if (m_in_frame) begin
        exp_frames++;
        m_idx = 0;
        m_bits = 0;
        m_shift = '0;
        m_in_frame = 1'b0;
      end
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic check_test(input string name);
    pix_t e;
    pix_t g;
    int   lat;
    chk({name, "_npix"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      lat = pv_lat_q.pop_front();
      chk({name, "_data"}, g.data, e.data);
      chk({name, "_idx"}, g.idx, e.idx);
      chk({name, "_pv_lat"}, lat, 3);
    end
    exp_q.delete();
    got_q.delete();
    pv_lat_q.delete();
    chk({name, "_frames"}, got_frames, exp_frames);
    chk({name, "_berr"}, got_berr, exp_berr);
    foreach (fd_lat_q[i])
      chk({name, "_fd_lat_ok"}, (fd_lat_q[i] >= RST_CYC && fd_lat_q[i] <= RST_CYC + 8), 1);
    fd_lat_q.delete();
    chk({name, "_coincide"}, coincide, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_data"}, pixelData, 0);
    chk({name, "_valid"}, pixelValid, 0);
    chk({name, "_index"}, pixelIndex, 0);
    chk({name, "_frame"}, frameDone, 0);
    chk({name, "_berr"}, bitError, 0);
    chk({name, "_dout"}, dout, 0);
  endtask

  initial begin
    logic [23:0] w0;
    logic [23:0] w1;
    din = 1'b0;
    reset = 1'b1;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // single pixel with nominal timing
    send_bits(24'hFF0000, 24, 1'b0);
    send_gap(GAP);
    check_test("single");

    // three back-to-back pixels
    send_bits(24'h123456, 24, 1'b0);
    send_bits(24'hABCDEF, 24, 1'b0);
    send_bits(24'h000001, 24, 1'b0);
    send_gap(GAP);
    check_test("three");

    // glitch mid-pixel, resync, then a clean pixel
    w0 = 24'($urandom);
    send_bits(w0, 8, 1'b1);
    send_pulse(10, 30);
    send_gap(GAP);
    check_test("glitch");
    w0 = 24'($urandom);
    send_bits(w0, 24, 1'b1);
    send_gap(GAP);
    check_test("after_glitch");

    // overlong pulse, resync, then a partial pixel before the latch
    send_pulse(150, 30);
    send_gap(GAP);
    w0 = 24'($urandom);
    send_bits(w0, 12, 1'b1);
    send_gap(GAP);
    check_test("long");

    // randomized words and timing
    w0 = 24'($urandom);
    w1 = 24'($urandom);
    send_bits(w0, 24, 1'b1);
    send_bits(w1, 24, 1'b1);
    send_gap(GAP);
    check_test("random");

    // async reset in the middle of the third pixel
    w0 = 24'($urandom) | 24'h000100;
    w1 = 24'($urandom) | 24'h000100;
    send_bits(w0, 24, 1'b1);
    send_bits(w1, 24, 1'b1);
    send_bits(24'($urandom), 12, 1'b1);
    check_test("pre_reset");
    #2;
    reset = 1'b1;
    m_bits = 0;
    m_shift = '0;
    m_idx = 0;
    m_in_frame = 1'b0;
    m_resync = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    w0 = 24'($urandom);
    send_bits(w0, 24, 1'b1);
    send_gap(GAP);
    check_test("post_reset");

    // forwarding: first pixel stripped, second reproduced
    din_p.delete();
    dout_p.delete();
    w0 = 24'($urandom);
    w1 = 24'($urandom);
    send_bits(w0, 24, 1'b1);
    send_bits(w1, 24, 1'b1);
    send_gap(GAP);
    check_test("fwd_decode");
`ifdef WS2812B_FORWARD_EN
    chk("fwd_npulse", dout_p.size(), 24);
    for (int k = 0; k < 24 && k < dout_p.size(); k++) begin
      chk("fwd_delay", dout_p[k].rise - din_p[24 + k].rise, 3);
      chk("fwd_width", dout_p[k].width, din_p[24 + k].width);
    end
`else
    chk("fwd_npulse", dout_p.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
